k_conv_scan_ctrl: RTL

//  Frame scan controller for the 3x3 convolution datapath (kernel weights 4/2/1).

---
 rtl/k_conv_scan_ctrl_if.sv | 31 +++
 rtl/k_conv_scan_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/k_conv_scan_ctrl_if.sv
// rtl/k_conv_scan_ctrl_if.sv - pixel handshake, line-buffer and window bundle for k_conv_scan_ctrl
interface k_conv_scan_ctrl_if #(
    parameter int COL_W = 8,
    parameter int ROW_W = 8
);
    logic             start;
    logic             enable;
    logic             pix_valid;
    logic             pix_ready;
    logic             lb_wr_en;
    logic [COL_W-1:0] lb_wr_addr;
    logic [1:0]       lb_wr_line;
    logic             win_valid;
    logic [COL_W-1:0] cen_col;
    logic [ROW_W-1:0] cen_row;
    logic [3:0]       border;
    logic             busy;
    logic             done;

    modport master (
        output start, enable, pix_valid,
        input  pix_ready, lb_wr_en, lb_wr_addr, lb_wr_line, win_valid,
               cen_col, cen_row, border, busy, done
    );

    modport slave (
        input  start, enable, pix_valid,
        output pix_ready, lb_wr_en, lb_wr_addr, lb_wr_line, win_valid,
               cen_col, cen_row, border, busy, done
    );
endinterface

// File: rtl/k_conv_scan_ctrl.sv
// rtl/k_conv_scan_ctrl.sv - 3x3 conv frame scan controller; ZERO_PAD_EN selects padded windows
module k_conv_scan_ctrl #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 240,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8
) (
    input logic clk,
    input logic rst,
    k_conv_scan_ctrl_if.slave bus
);
    localparam int LIN_W = $clog2(WIDTH * HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] in_col_q, in_col_d;
    logic [ROW_W-1:0] in_row_q, in_row_d;
    logic [1:0]       bank_q, bank_d;
    logic [LIN_W-1:0] lin_q, lin_d;
    logic [COL_W-1:0] cen_col_q, cen_col_d;
    logic [ROW_W-1:0] cen_row_q, cen_row_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             pix_ready;
    logic             accept;
    logic             last_in;
    logic             go_done;
    logic             win_valid;
    logic [COL_W-1:0] cen_col_nx;
    logic [ROW_W-1:0] cen_row_nx;

    assign pix_ready = bus.enable && (state_q == S_FILL || state_q == S_RUN);
    assign accept    = bus.pix_valid && pix_ready;
    assign last_in   = (in_col_q == COL_LAST) && (in_row_q == ROW_LAST);

    assign cen_col_nx = (cen_col_q == COL_LAST) ? '0 : cen_col_q + COL_W'(1);
    assign cen_row_nx = (cen_col_q == COL_LAST) ? cen_row_q + ROW_W'(1) : cen_row_q;

`ifdef ZERO_PAD_EN
    logic cen_last;
    assign cen_last  = (cen_col_q == COL_LAST) && (cen_row_q == ROW_LAST);
    assign win_valid = (accept && state_q == S_RUN) || (state_q == S_FLUSH && bus.enable);
    assign bus.border = win_valid ? {cen_row_q == '0, cen_row_q == ROW_LAST,
                                     cen_col_q == '0, cen_col_q == COL_LAST} : 4'b0000;
`else
    localparam logic [COL_W-1:0] COL_HI = COL_W'(WIDTH - 2);
    localparam logic [ROW_W-1:0] ROW_HI = ROW_W'(HEIGHT - 2);
    assign win_valid = accept && state_q == S_RUN
                       && cen_col_q >= COL_W'(1) && cen_col_q <= COL_HI
                       && cen_row_q >= ROW_W'(1) && cen_row_q <= ROW_HI;
    assign bus.border = 4'b0000;
`endif

    // start is honoured in IDLE and DONE always returns to IDLE, even while stalled,
    // so a start pulse is never lost and done stays a single-cycle pulse.
    always_comb begin
        state_d   = state_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        bank_d    = bank_q;
        lin_d     = lin_q;
        cen_col_d = cen_col_q;
        cen_row_d = cen_row_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        go_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FILL;
                    busy_d  = 1'b1;
                end
            end
            S_FILL, S_RUN: begin
                if (accept) begin
                    lin_d = lin_q + LIN_W'(1);
                    if (in_col_q == COL_LAST) begin
                        in_col_d = '0;
                        in_row_d = in_row_q + ROW_W'(1);
                        bank_d   = (bank_q == 2'd2) ? 2'd0 : bank_q + 2'd1;
                    end else begin
                        in_col_d = in_col_q + COL_W'(1);
                    end
                    if (state_q == S_FILL && lin_q == LIN_W'(WIDTH)) begin
                        state_d = S_RUN;
                    end
                    if (state_q == S_RUN) begin
                        cen_col_d = cen_col_nx;
                        cen_row_d = cen_row_nx;
                    end
                    if (last_in) begin
`ifdef ZERO_PAD_EN
                        state_d  = S_FLUSH;
                        in_col_d = '0;
                        in_row_d = '0;
                        bank_d   = '0;
                        lin_d    = '0;
`else
                        go_done  = 1'b1;
`endif
                    end
                end
            end
            S_FLUSH: begin
                if (bus.enable) begin
`ifdef ZERO_PAD_EN
                    if (cen_last) begin
                        go_done = 1'b1;
                    end else begin
                        cen_col_d = cen_col_nx;
                        cen_row_d = cen_row_nx;
                    end
`else
                    go_done = 1'b1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (go_done) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            in_col_d  = '0;
            in_row_d  = '0;
            bank_d    = '0;
            lin_d     = '0;
            cen_col_d = '0;
            cen_row_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_col_q  <= '0;
            in_row_q  <= '0;
            bank_q    <= '0;
            lin_q     <= '0;
            cen_col_q <= '0;
            cen_row_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            bank_q    <= bank_d;
            lin_q     <= lin_d;
            cen_col_q <= cen_col_d;
            cen_row_q <= cen_row_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.lb_wr_en   = accept;
    assign bus.lb_wr_addr = in_col_q;
    assign bus.lb_wr_line = bank_q;
    assign bus.win_valid  = win_valid;
    assign bus.cen_col    = cen_col_q;
    assign bus.cen_row    = cen_row_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
